bp_be_fp_bypass_sb: RTL and testbench
=====================================

// Module: bp_be_fp_bypass_sb
// PURPOSE
//  Next-generation FP operand bypass for the BE calculator: N-source bypass plus an in-flight scoreboard.
//  Tracks FP rd registers issued but not yet written back, and stalls dispatch on RAW/WAW hazards.
//  Keeps a stages_p-deep history of completed writebacks not yet visible in the FP regfile.
//  Forwards the youngest matching value per source operand; sits between FP regfile read and FP pipes.
// PARAMETERS
//  rs_els_p      3   number of source operands bypassed (1..4)
//  stages_p      3   writeback history depth (1..8); writeback-to-regfile-visible latency in cycles
//  data_width_p  64  operand/result width
//  addr_width_p  5   register address width; scoreboard holds 2**addr_width_p bits
// PORTS
//  clk_i              in   1                        clock
//  reset_i            in   1                        asynchronous, active-high reset
//  dispatch_v_i       in   1                        instruction presented for dispatch
//  dispatch_rd_w_v_i  in   1                        presented instruction writes rd
//  dispatch_rd_addr_i in   addr_width_p             destination register
//  rs_r_v_i           in   rs_els_p                 per-source read-valid
//  rs_addr_i          in   rs_els_p*addr_width_p    source addresses
//  rs_data_i          in   rs_els_p*data_width_p    regfile read data
//  wb_v_i             in   1                        FP result completing this cycle
//  wb_rd_addr_i       in   addr_width_p             completing rd
//  wb_data_i          in   data_width_p             completing result
//  flush_i            in   1                        squash all in-flight (not-yet-completed) ops
//  bypass_rs_o        out  rs_els_p*data_width_p    forwarded operands (combinational)
//  stall_o            out  1                        dispatch must hold (combinational)
//  dispatch_yumi_o    out  1                        dispatch_v_i & ~stall_o
//  wb_err_o           out  1                        sticky: writeback to non-pending rd
// BEHAVIOUR
//  - Reset: pending[] = 0, hist_v[] = 0, wb_err_o = 0; stall_o = 0 with all inputs low.
//  - Bypass priority per source i: live wb (wb_v_i & addr match) > hist[0] (newest) > ... > hist[stages_p-1] > rs_data_i.
//    Source with rs_r_v_i[i] = 0 still outputs rs_data_i unmodified.
//  - History: shift register; each cycle hist[0] <= {wb_v_i, wb_rd_addr_i, wb_data_i}, hist[k] <= hist[k-1].
//    An entry leaving hist[stages_p-1] is visible in the regfile; no backpressure.
//  - RAW hazard i: rs_r_v_i[i] & pending[rs_addr_i[i]] & ~(wb_v_i & wb_rd_addr_i == rs_addr_i[i]).
//  - WAW hazard: dispatch_rd_w_v_i & pending[dispatch_rd_addr_i] & ~(wb_v_i & same addr).
//  - stall_o = dispatch_v_i & (any RAW | WAW); zero-cycle resolution when result arrives the same cycle.
//  - Accept (dispatch_yumi_o) with dispatch_rd_w_v_i: pending[rd] <= 1 next cycle.
//  - wb_v_i: pending[wb_rd_addr_i] <= 0. Same-cycle set and clear of the same rd: set wins.
//  - wb_v_i while pending[wb_rd_addr_i] = 0 sets wb_err_o; it is cleared only by reset.
//  - flush_i: all pending <= 0 next cycle; the accept in that cycle is also discarded.
//    History is kept, since completed data is architecturally valid; same-cycle wb still enters the history.
//  - Reset asserted mid-operation: all state cleared immediately, including in-flight pending and history.
//  - No latency on data paths; state updates take effect on the next rising clock edge.
// CONFIGURATION
//  BP_BE_FP_BYPASS_SB_PERF_EN
//   defined: extra port stall_cnt_o out 32, counting cycles with stall_o = 1.
//     Saturates at 32'hFFFF_FFFF; reset to 0.
//   undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset, rs_data_i=A for all i, no wb -> bypass_rs_o = A each, stall_o=0, wb_err_o=0.
//  2 dispatch rd=f3; next cycle dispatch rs1=f3 -> stall_o=1.
//    wb f3=0x40 arrives -> stall_o=0 same cycle, bypass rs1=0x40.
//  3 wb f5=0x11 at t, wb f5=0x22 at t+1; read f5 at t+2 -> 0x22.
//    Read at t+1+stages_p -> 0x22 from history; afterwards rs_data_i passes through.
//  4 pending f7; dispatch rd=f7 -> WAW stall; same-cycle wb f7 -> accepted, pending[f7]=1 afterwards.
//  5 pending f1,f2; flush_i -> next cycle reading f1/f2 does not stall.
//    Then wb f1 -> wb_err_o=1 and stays 1.
//  6 (PERF_EN) hold a RAW stall for 10 cycles -> stall_cnt_o=10. Force near-saturation -> holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/bp_be_fp_bypass_sb.sv
// FP operand bypass network with in-flight destination scoreboard.
// Forwards the youngest completed FP result to each source operand and stalls
// dispatch on RAW/WAW hazards against registers still in flight.
// Optional feature macro: BP_BE_FP_BYPASS_SB_PERF_EN adds a saturating stall counter.
module bp_be_fp_bypass_sb #(
   parameter int unsigned rs_els_p     = 3,
   parameter int unsigned stages_p     = 3,
   parameter int unsigned data_width_p = 64,
   parameter int unsigned addr_width_p = 5
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               dispatch_v_i,
   input  logic                               dispatch_rd_w_v_i,
   input  logic [addr_width_p-1:0]            dispatch_rd_addr_i,
   input  logic [rs_els_p-1:0]                rs_r_v_i,
   input  logic [rs_els_p*addr_width_p-1:0]   rs_addr_i,
   input  logic [rs_els_p*data_width_p-1:0]   rs_data_i,
   input  logic                               wb_v_i,
   input  logic [addr_width_p-1:0]            wb_rd_addr_i,
   input  logic [data_width_p-1:0]            wb_data_i,
   input  logic                               flush_i,
   output logic [rs_els_p*data_width_p-1:0]   bypass_rs_o,
   output logic                               stall_o,
   output logic                               dispatch_yumi_o,
   output logic                               wb_err_o
`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
   ,output logic [31:0]                       stall_cnt_o
`endif
);

   localparam int unsigned regs_lp = 2 ** addr_width_p;

   logic [regs_lp-1:0]      pending_r, pending_n;
   logic [stages_p-1:0]     hist_v_r;
   logic [addr_width_p-1:0] hist_addr_r [stages_p];
   logic [data_width_p-1:0] hist_data_r [stages_p];
   logic [rs_els_p-1:0]     raw;
   logic                    waw;
   logic                    wb_err_n;

   // Operand select: oldest history entry first so younger matches overwrite it
   always_comb begin
      bypass_rs_o = rs_data_i;
      for (int i = 0; i < int'(rs_els_p); i++) begin
         if (rs_r_v_i[i]) begin
            for (int k = int'(stages_p) - 1; k >= 0; k--) begin
               if (hist_v_r[k] && (hist_addr_r[k] == rs_addr_i[i*addr_width_p +: addr_width_p]))
                  bypass_rs_o[i*data_width_p +: data_width_p] = hist_data_r[k];
            end
            if (wb_v_i && (wb_rd_addr_i == rs_addr_i[i*addr_width_p +: addr_width_p]))
               bypass_rs_o[i*data_width_p +: data_width_p] = wb_data_i;
         end
      end
   end

   // Hazard detection; a result arriving this cycle resolves its hazard immediately
   always_comb begin
      raw = '0;
      for (int i = 0; i < int'(rs_els_p); i++) begin
         raw[i] = rs_r_v_i[i]
                & pending_r[rs_addr_i[i*addr_width_p +: addr_width_p]]
                & ~(wb_v_i & (wb_rd_addr_i == rs_addr_i[i*addr_width_p +: addr_width_p]));
      end
      waw = dispatch_rd_w_v_i & pending_r[dispatch_rd_addr_i]
          & ~(wb_v_i & (wb_rd_addr_i == dispatch_rd_addr_i));
   end

   assign stall_o         = dispatch_v_i & ((|raw) | waw);
   assign dispatch_yumi_o = dispatch_v_i & ~stall_o;

   // Scoreboard next state: clear on writeback, set on accept (set wins), flush drops everything
   always_comb begin
      pending_n = pending_r;
      wb_err_n  = wb_err_o;
      if (wb_v_i) begin
         if (!pending_r[wb_rd_addr_i])
            wb_err_n = 1'b1;
         pending_n[wb_rd_addr_i] = 1'b0;
      end
      if (dispatch_yumi_o && dispatch_rd_w_v_i)
         pending_n[dispatch_rd_addr_i] = 1'b1;
      if (flush_i)
         pending_n = '0;
   end

   // Scoreboard and sticky error registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pending_r <= '0;
         wb_err_o  <= 1'b0;
      end else begin
         pending_r <= pending_n;
         wb_err_o  <= wb_err_n;
      end
   end

   // Writeback history shift register covering regfile write latency
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hist_v_r <= '0;
         for (int k = 0; k < int'(stages_p); k++) begin
            hist_addr_r[k] <= '0;
            hist_data_r[k] <= '0;
         end
      end else begin
         hist_v_r[0]    <= wb_v_i;
         hist_addr_r[0] <= wb_rd_addr_i;
         hist_data_r[0] <= wb_data_i;
         for (int k = 1; k < int'(stages_p); k++) begin
            hist_v_r[k]    <= hist_v_r[k-1];
            hist_addr_r[k] <= hist_addr_r[k-1];
            hist_data_r[k] <= hist_data_r[k-1];
         end
      end
   end

`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
   // Saturating count of stalled cycles
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         stall_cnt_o <= '0;
      else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_bp_be_fp_bypass_sb.sv
// Self-checking bench for bp_be_fp_bypass_sb: directed scenarios plus a randomized
// phase against a behavioural scoreboard/history model.
module tb_bp_be_fp_bypass_sb;
   localparam int unsigned RS = 3;
   localparam int unsigned ST = 3;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 5;

   logic              clk = 1'b0;
   logic              reset_i;
   logic              dispatch_v_i, dispatch_rd_w_v_i;
   logic [AW-1:0]     dispatch_rd_addr_i;
   logic [RS-1:0]     rs_r_v_i;
   logic [RS*AW-1:0]  rs_addr_i;
   logic [RS*DW-1:0]  rs_data_i;
   logic              wb_v_i;
   logic [AW-1:0]     wb_rd_addr_i;
   logic [DW-1:0]     wb_data_i;
   logic              flush_i;
   logic [RS*DW-1:0]  bypass_rs_o;
   logic              stall_o, dispatch_yumi_o, wb_err_o;
`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
   logic [31:0]       stall_cnt_o;
`endif

   always #5 clk = ~clk;

   bp_be_fp_bypass_sb #(.rs_els_p(RS), .stages_p(ST), .data_width_p(DW), .addr_width_p(AW)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .dispatch_v_i(dispatch_v_i), .dispatch_rd_w_v_i(dispatch_rd_w_v_i),
      .dispatch_rd_addr_i(dispatch_rd_addr_i),
      .rs_r_v_i(rs_r_v_i), .rs_addr_i(rs_addr_i), .rs_data_i(rs_data_i),
      .wb_v_i(wb_v_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i), .bypass_rs_o(bypass_rs_o), .stall_o(stall_o),
      .dispatch_yumi_o(dispatch_yumi_o), .wb_err_o(wb_err_o)
`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   typedef struct packed {
      logic [2:0]  kind;   // 0 bypass, 1 stall, 2 yumi, 3 wb_err, 4 stall_cnt
      logic [1:0]  idx;
      logic [63:0] val;
   } exp_t;

   exp_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   string kname[5] = '{"bypass", "stall", "yumi", "wb_err", "stall_cnt"};

   localparam logic [63:0] A = 64'hA5A5_0000_1234_5678;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input logic [2:0] kind, input logic [1:0] idx);
      case (kind)
         3'd0:    return bypass_rs_o[int'(idx)*DW +: DW];
         3'd1:    return 64'(stall_o);
         3'd2:    return 64'(dispatch_yumi_o);
         3'd3:    return 64'(wb_err_o);
`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
         3'd4:    return 64'(stall_cnt_o);
`endif
         default: return 64'hDEAD;
      endcase
   endfunction

   task automatic expect_v(input int kind, input int idx, input logic [63:0] val);
      exp_t e;
      e.kind = 3'(kind);
      e.idx  = 2'(idx);
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Sample on the falling edge, compare everything queued, then advance past the rising edge
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s%0d", kname[e.kind], e.idx), observe(e.kind, e.idx), e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dispatch_v_i = 0; dispatch_rd_w_v_i = 0; dispatch_rd_addr_i = '0;
      rs_r_v_i = '0; rs_addr_i = '0;
      for (int i = 0; i < int'(RS); i++) rs_data_i[i*DW +: DW] = A;
      wb_v_i = 0; wb_rd_addr_i = '0; wb_data_i = '0; flush_i = 0;
   endtask

   task automatic set_rs(input int i, input logic v, input int addr, input logic [63:0] data);
      rs_r_v_i[i] = v;
      rs_addr_i[i*AW +: AW] = AW'(addr);
      rs_data_i[i*DW +: DW] = data;
   endtask

   task automatic dispatch(input logic wr, input int rd);
      dispatch_v_i = 1; dispatch_rd_w_v_i = wr; dispatch_rd_addr_i = AW'(rd);
   endtask

   task automatic wb(input int rd, input logic [63:0] data);
      wb_v_i = 1; wb_rd_addr_i = AW'(rd); wb_data_i = data;
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1;
      @(posedge clk);
      #1;
      reset_i = 0;
   endtask

   // Behavioural model for the random phase
   logic          m_pend [8];
   logic          m_err;
   logic          h_v [ST];
   logic [AW-1:0] h_a [ST];
   logic [63:0]   h_d [ST];

   initial begin
      reset_i = 1;
      idle();
      @(posedge clk);
      #1;
      reset_i = 0;

      // Reset state: pass-through, no stall, no error
      for (int i = 0; i < int'(RS); i++) set_rs(i, 1'b1, i + 1, A);
      for (int i = 0; i < int'(RS); i++) expect_v(0, i, A);
      expect_v(1, 0, 0); expect_v(3, 0, 0);
      cyc();

      // RAW stall, resolved the same cycle the result arrives
      idle(); dispatch(1, 3);
      expect_v(2, 0, 1); expect_v(1, 0, 0);
      cyc();
      idle(); dispatch(0, 0); set_rs(0, 1, 3, A);
      expect_v(1, 0, 1); expect_v(2, 0, 0); expect_v(0, 0, A);
      cyc();
      idle(); dispatch(0, 0); set_rs(0, 1, 3, A); wb(3, 64'h40);
      expect_v(1, 0, 0); expect_v(2, 0, 1); expect_v(0, 0, 64'h40);
      cyc();
      idle(); expect_v(3, 0, 0);
      cyc();

      // Youngest-wins forwarding and history aging
      do_reset();
      wb(5, 64'h11); cyc();
      idle(); wb(5, 64'h22); cyc();
      idle(); set_rs(0, 1, 5, 64'hBB); set_rs(1, 0, 5, 64'hCC); set_rs(2, 1, 5, 64'hDD);
      expect_v(0, 0, 64'h22); expect_v(0, 1, 64'hCC); expect_v(0, 2, 64'h22);
      cyc();
      idle(); set_rs(0, 1, 5, 64'hBB); cyc();           // t+3
      idle(); set_rs(0, 1, 5, 64'hBB);                  // t+1+stages_p
      expect_v(0, 0, 64'h22);
      cyc();
      idle(); set_rs(0, 1, 5, 64'hBB);
      expect_v(0, 0, 64'hBB); expect_v(3, 0, 1);
      cyc();

      // WAW stall and same-cycle set-wins
      do_reset();
      expect_v(3, 0, 0);
      dispatch(1, 7); expect_v(2, 0, 1); cyc();
      idle(); dispatch(1, 7); expect_v(1, 0, 1); expect_v(2, 0, 0); cyc();
      idle(); dispatch(1, 7); wb(7, 64'h77); expect_v(1, 0, 0); expect_v(2, 0, 1); cyc();
      idle(); dispatch(0, 0); set_rs(1, 1, 7, A); expect_v(1, 0, 1); cyc();

      // Flush drops in-flight ops including a same-cycle accept; stray wb is sticky error
      do_reset();
      dispatch(1, 1); cyc();
      idle(); dispatch(1, 2); cyc();
      idle(); dispatch(1, 4); flush_i = 1; expect_v(2, 0, 1); cyc();
      idle(); dispatch(0, 0); set_rs(0, 1, 1, A); set_rs(1, 1, 2, A); set_rs(2, 1, 4, A);
      expect_v(1, 0, 0); expect_v(3, 0, 0);
      cyc();
      idle(); wb(1, 64'h5); cyc();
      idle(); expect_v(3, 0, 1); cyc();
      idle(); expect_v(3, 0, 1); cyc();

      // Asynchronous reset mid-operation clears pending, history and error
      do_reset();
      dispatch(1, 6); wb(9, 64'h99); cyc();
      idle();
      reset_i = 1; #2; reset_i = 0;
      dispatch(0, 0); set_rs(0, 1, 6, A); set_rs(1, 1, 9, 64'h123);
      expect_v(1, 0, 0); expect_v(0, 1, 64'h123); expect_v(3, 0, 0);
      cyc();

`ifdef BP_BE_FP_BYPASS_SB_PERF_EN
      // Stall counter over a 10-cycle RAW stall
      do_reset();
      dispatch(1, 2); cyc();
      for (int n = 0; n < 10; n++) begin
         idle(); dispatch(0, 0); set_rs(0, 1, 2, A); cyc();
      end
      idle(); expect_v(4, 0, 10); cyc();
`endif

      // Randomized traffic against the model
      do_reset();
      for (int a = 0; a < 8; a++) m_pend[a] = 0;
      m_err = 0;
      for (int k = 0; k < int'(ST); k++) begin h_v[k] = 0; h_a[k] = '0; h_d[k] = '0; end
      for (int n = 0; n < 300; n++) begin
         logic raw_any, waw_m, stall_m, yumi_m;
         idle();
         dispatch_v_i       = 1'($urandom_range(1));
         dispatch_rd_w_v_i  = 1'($urandom_range(1));
         dispatch_rd_addr_i = AW'($urandom_range(7));
         for (int i = 0; i < int'(RS); i++)
            set_rs(i, 1'($urandom_range(1)), int'($urandom_range(7)), {$urandom, $urandom});
         wb_v_i       = 1'($urandom_range(1));
         wb_rd_addr_i = AW'($urandom_range(7));
         wb_data_i    = {$urandom, $urandom};
         flush_i      = ($urandom_range(15) == 0);

         raw_any = 0;
         for (int i = 0; i < int'(RS); i++) begin
            logic [AW-1:0] ra;
            logic [63:0]   e;
            logic          found;
            ra = rs_addr_i[i*AW +: AW];
            e  = rs_data_i[i*DW +: DW];
            found = 0;
            if (rs_r_v_i[i]) begin
               if (wb_v_i && wb_rd_addr_i == ra) begin
                  e = wb_data_i; found = 1;
               end
               for (int k = 0; k < int'(ST); k++)
                  if (!found && h_v[k] && h_a[k] == ra) begin e = h_d[k]; found = 1; end
               if (m_pend[ra[2:0]] && !(wb_v_i && wb_rd_addr_i == ra)) raw_any = 1;
            end
            expect_v(0, i, e);
         end
         waw_m   = dispatch_rd_w_v_i && m_pend[dispatch_rd_addr_i[2:0]]
                   && !(wb_v_i && wb_rd_addr_i == dispatch_rd_addr_i);
         stall_m = dispatch_v_i && (raw_any || waw_m);
         yumi_m  = dispatch_v_i && !stall_m;
         expect_v(1, 0, 64'(stall_m));
         expect_v(2, 0, 64'(yumi_m));
         expect_v(3, 0, 64'(m_err));
         cyc();

         if (wb_v_i) begin
            if (!m_pend[wb_rd_addr_i[2:0]]) m_err = 1;
            m_pend[wb_rd_addr_i[2:0]] = 0;
         end
         if (yumi_m && dispatch_rd_w_v_i) m_pend[dispatch_rd_addr_i[2:0]] = 1;
         if (flush_i) for (int a = 0; a < 8; a++) m_pend[a] = 0;
         for (int k = int'(ST) - 1; k > 0; k--) begin
            h_v[k] = h_v[k-1]; h_a[k] = h_a[k-1]; h_d[k] = h_d[k-1];
         end
         h_v[0] = wb_v_i; h_a[0] = wb_rd_addr_i; h_d[0] = wb_data_i;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
